ring_sequencer_n: RTL
=====================

Name: ring_sequencer_n

Overview:
- Parametrised T-state ring sequencer for the 8-bit CPU control path; next generation of the fixed 6-step sequencer.
- Generates a one-hot timing state (T1..TN) plus a binary state index, which drive the control-word decoder.
- Adds features the fixed sequencer lacks: N-state ring, early instruction termination, run/hold, sticky halt, instruction counter and a registered cycle-done pulse.
- Sits between the clock/reset source and the controller/decoder.

Parameters:
- NUM_STATES, 6, number of T-states in the ring; legal range 2..16.
- IDX_W, $clog2(NUM_STATES), width of the binary index; derived, do not override.
- CNT_W, 8, width of the completed-instruction counter.

Ports:
- dummy_clk  in  1  system clock; all state updates on its rising edge.
- FPGA_inp_zero  in  1  reset; synchronous, active-high.
- run  in  1  advance enable; 0 holds the current state.
- ring_clr  in  1  early end of instruction; the next state is T1.
- hlt  in  1  halt request; freezes the sequencer until reset.
- t_state  out  NUM_STATES  one-hot T-state; bit 0 is T1.
- t_idx  out  IDX_W  binary index of the active T-state (0 = T1).
- cycle_done  out  1  one-cycle pulse registered on completion of an instruction cycle.
- instr_cnt  out  CNT_W  count of completed instruction cycles.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset: the synchronous reset (FPGA_inp_zero = 1 at a clock edge) sets the following:
  - t_state = 1 (T1) and t_idx = 0.
  - cycle_done = 0, instr_cnt = 0, halted = 0.
- Reset takes effect at the edge where it is asserted, including mid-instruction and while halted. While reset is held, outputs stay at their reset values.
- Per-edge priority: reset > halted/hlt > ring_clr > normal advance > hold.
- Halt:
  - hlt = 1 at an edge: halted <= 1. t_state, t_idx and instr_cnt hold. cycle_done <= 0.
  - Once halted = 1, run, ring_clr and hlt are ignored until reset.
- Early end: ring_clr = 1 with run = 1 and not halted at an edge has these effects:
  - t_state <= T1 and t_idx <= 0.
  - cycle_done <= 1 and instr_cnt <= instr_cnt + 1.
  - Asserted while in T1, it holds T1 and still counts the instruction.
- Normal advance: run = 1, ring_clr = 0, not halted:
  - From Tk (k < N), the one-hot shifts left, t_idx increments and cycle_done <= 0.
  - From TN, the state wraps to T1, t_idx <= 0, cycle_done <= 1 and instr_cnt increments.
- run = 0 (not halted): all state holds, cycle_done <= 0, and ring_clr is ignored.
- instr_cnt wraps modulo 2^CNT_W with no saturation or flag.
- Latency: one edge per state change. t_state and t_idx are registered and always consistent, with exactly one bit of t_state high at all times.
- cycle_done is high during the first T1 of the following instruction.
- Invalid one-hot (not reachable): the next edge forces T1. The checker flags it as an error.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined: the block adds the input ports step_mode (1) and step_btn (1).
  - step_btn is registered, and its rising edge is detected internally.
  - When step_mode = 1, the advance/ring_clr condition requires a detected step_btn rising edge in addition to run = 1. This gives exactly one state change per press, and a held button yields only one step.
  - When step_mode = 0, behaviour is identical to the base block.
  - The edge-detect register resets to 0.
- Undefined: neither port exists, and the block advances on every enabled edge.

Test Plan:
- Reset then free-run: NUM_STATES = 6, run = 1 for 13 cycles.
  - Response: t_state 01→02→04→08→10→20→01...
  - cycle_done pulses at cycles 6 and 12.
  - instr_cnt = 2 after cycle 12.
- Early end: with t_state = 08 (T4), pulse ring_clr for one cycle.
  - Response: t_state = 01 next cycle, cycle_done = 1, instr_cnt increments by 1.
  - Same stimulus with run = 0: no change.
- Halt: assert hlt in T3 together with ring_clr.
  - Response: halted = 1 and t_state stays 04 for 20 cycles with run = 1.
  - instr_cnt is unchanged; a later reset restores t_state = 01 and halted = 0.
- Reset mid-operation: assert FPGA_inp_zero in T5 for one cycle.
  - Response: next edge gives t_state = 01, t_idx = 0, instr_cnt = 0, cycle_done = 0.
- Counter wrap and generic N: NUM_STATES = 2, CNT_W = 3, run for 16 cycles.
  - Response: instr_cnt sequence 1..7,0 and t_idx toggles 0/1.
  - Exactly one t_state bit is high on every cycle.
- SEQ_SINGLE_STEP_EN: step_mode = 1, run = 1, step_btn held high for 10 cycles then low, then pulsed three times.
  - Response: the held button gives exactly 1 advance; the three pulses give 3 more, so t_state = 10 (T5).

Source files
------------

// File: rtl/ring_sequencer_n.sv
// Parametrised T-state ring sequencer: one-hot T1..TN plus binary index, early end, run/hold,
// sticky halt, instruction counter and cycle-done pulse. Optional single-step: SEQ_SINGLE_STEP_EN.
module ring_sequencer_n #(
  parameter int NUM_STATES = 6,
  parameter int IDX_W      = $clog2(NUM_STATES),
  parameter int CNT_W      = 8
) (
  input  logic                  dummy_clk,
  input  logic                  FPGA_inp_zero,
  input  logic                  run,
  input  logic                  ring_clr,
  input  logic                  hlt,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step_mode,
  input  logic                  step_btn,
`endif
  output logic [NUM_STATES-1:0] t_state,
  output logic [IDX_W-1:0]      t_idx,
  output logic                  cycle_done,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic                  halted
);

  localparam logic [NUM_STATES-1:0] T1 = NUM_STATES'(1);

  logic step_ok;
  logic advance;
  logic at_last;
  logic onehot_ok;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_btn_q;

  always_ff @(posedge dummy_clk) begin
    if (FPGA_inp_zero) step_btn_q <= 1'b0;
    else               step_btn_q <= step_btn;
  end

  // A held button produces a single rising edge, hence a single step.
  assign step_ok = !step_mode || (step_btn && !step_btn_q);
`else
  assign step_ok = 1'b1;
`endif

  assign advance   = run && step_ok;
  assign at_last   = t_state[NUM_STATES-1];
  assign onehot_ok = $onehot(t_state);

  // NOTE: every register here is assigned with <= so all of them see pre-edge values.
  always_ff @(posedge dummy_clk) begin
    if (FPGA_inp_zero) begin
      t_state    <= T1;
      t_idx      <= '0;
      cycle_done <= 1'b0;
      instr_cnt  <= '0;
      halted     <= 1'b0;
    end else if (halted) begin
      cycle_done <= 1'b0;
    end else if (hlt) begin
      halted     <= 1'b1;
      cycle_done <= 1'b0;
    end else if (!onehot_ok) begin
      // Corrupted ring recovers to T1 rather than propagating a bad control word.
      t_state    <= T1;
      t_idx      <= '0;
      cycle_done <= 1'b0;
    end else if (advance) begin
      if (ring_clr || at_last) begin
        t_state    <= T1;
        t_idx      <= '0;
        cycle_done <= 1'b1;
        instr_cnt  <= instr_cnt + CNT_W'(1);
      end else begin
        t_state    <= {t_state[NUM_STATES-2:0], 1'b0};
        t_idx      <= t_idx + IDX_W'(1);
        cycle_done <= 1'b0;
      end
    end else begin
      cycle_done <= 1'b0;
    end
  end

endmodule
